// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int CLK_HZ       = 12_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte strobes of the UART receiver.
interface uart_rx_if;

  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_busy;

  modport master (
    input  rx,
    output rx_byte,
    output rx_valid,
    output rx_error,
    output rx_busy
  );

  modport slave (
    output rx,
    input  rx_byte,
    input  rx_valid,
    input  rx_error,
    input  rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous pin inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; delivers each good byte with a one-cycle strobe.
//
// state | meaning
// IDLE  | line high, waiting for a start bit
// START | counting to the start-bit centre, rejecting glitches
// DATA  | sampling the 8 data bits at their centres
// STOP  | sampling the stop bit; good frame or framing error
// BREAK | line must be seen high before the next start bit
module uart_rx
  import uart_pkg::*;
(
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BRK_ARM   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BREAK;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_s) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BREAK: begin
        // rx_s must stay high for three edges so the synchronizer's reset
        // value flushing out is never mistaken for a real idle line.
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == BRK_ARM) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_BREAK;
    endcase
  end

  assign bus.rx_byte  = byte_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_error = error_q;
  assign bus.rx_busy  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected strobes, a monitor pops and checks them.
module tb_uart_rx;

  logic clk;
  logic rst;
  int   cyc;
  int   passed;
  int   total;
  logic [7:0] last_good;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at_cyc;
  } exp_t;

  exp_t sb_q[$];

  uart_rx_if u_if ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Caller must be sitting at a negedge; the start bit begins at this negedge,
  // so a strobe is expected 3 (sync + detect) + 988 edges later.
  task automatic send_frame(input logic [7:0] d, input int n, input logic stop_lvl,
                            input bit expect_strobe);
    exp_t e;
    if (expect_strobe) begin
      e.is_err = !stop_lvl;
      e.data   = stop_lvl ? d : last_good;
      e.at_cyc = cyc + 991;
      sb_q.push_back(e);
      if (stop_lvl) last_good = d;
    end
    u_if.rx = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      repeat (n) @(negedge clk);
    end
    u_if.rx = stop_lvl;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (u_if.rx_valid || u_if.rx_error)) begin
      chk("strobe_exclusive", int'(u_if.rx_valid & u_if.rx_error), 0);
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got valid=%0b error=%0b byte=0x%0h, expected none (cycle %0d)",
                 u_if.rx_valid, u_if.rx_error, u_if.rx_byte, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_kind_is_err", int'(u_if.rx_error), int'(e.is_err));
        chk("rx_byte", int'(u_if.rx_byte), int'(e.data));
        chk("strobe_cycle", cyc, e.at_cyc);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    passed    = 0;
    total     = 0;
    last_good = 8'h00;
    rst       = 1'b1;
    u_if.rx   = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_rx_byte", int'(u_if.rx_byte), 0);
    chk("reset_rx_valid", int'(u_if.rx_valid), 0);
    chk("reset_rx_error", int'(u_if.rx_error), 0);
    chk("reset_rx_busy", int'(u_if.rx_busy), 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    send_frame(8'h55, 104, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    // back-to-back: second start bit right after the first stop bit
    send_frame(8'hA5, 104, 1'b1, 1'b1);
    send_frame(8'h3C, 104, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    // 30-clock glitch: busy rises at E0 = t0+3 and falls at E0+52
    t0 = cyc;
    u_if.rx = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch_busy_before_e0", int'(u_if.rx_busy), 0);
    @(negedge clk);
    chk("glitch_busy_at_e0", int'(u_if.rx_busy), 1);
    repeat (27) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (24) @(negedge clk);
    chk("glitch_busy_before_fall", int'(u_if.rx_busy), 1);
    @(negedge clk);
    chk("glitch_busy_fell", int'(u_if.rx_busy), 0);
    chk("glitch_fall_cycle", cyc - t0, 55);
    repeat (200) @(negedge clk);
    send_frame(8'h12, 104, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    // framing error, then line held low
    send_frame(8'hFF, 104, 1'b0, 1'b1);
    repeat (1896) @(negedge clk);
    chk("break_busy_low", int'(u_if.rx_busy), 0);
    u_if.rx = 1'b1;
    repeat (200) @(negedge clk);
    send_frame(8'h12, 104, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    // reset during data bit 3 of 0x81, released while the line is low
    u_if.rx = 1'b0;
    repeat (104) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (104) @(negedge clk);
    u_if.rx = 1'b0;
    repeat (208) @(negedge clk);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midframe_reset_rx_byte", int'(u_if.rx_byte), 0);
    chk("midframe_reset_rx_busy", int'(u_if.rx_busy), 0);
    chk("midframe_reset_rx_valid", int'(u_if.rx_valid), 0);
    chk("midframe_reset_rx_error", int'(u_if.rx_error), 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("post_reset_low_busy", int'(u_if.rx_busy), 0);
    u_if.rx = 1'b1;
    repeat (200) @(negedge clk);
    send_frame(8'h7E, 104, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    // baud mismatch
    send_frame(8'hC3, 100, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    send_frame(8'hC3, 108, 1'b1, 1'b1);
    repeat (1100) @(negedge clk);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the icestick UART path: 8N1, LSB first, 115200 baud from the 12 MHz board clock. It is the receive-side counterpart of the transmitter, samples the `rx` pin and delivers each received byte with a one-cycle strobe. Downstream logic either consumes the strobe directly or loops the byte back into the transmitter. Frames with a bad stop bit are flagged and never delivered as data.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `CLKS_PER_BIT`, `CLK_HZ/BAUD` (104), clocks per bit period
- `HALF_BIT`, `CLKS_PER_BIT/2` (52), clocks from start-bit detect to start-bit centre
- `clk`  input  1  system clock; every register updates on the rising edge
- `rst`  input  1  reset, synchronous, active-high
- `rx`  input  1  asynchronous serial line; idle is high
- `rx_byte`  output  8  last correctly framed byte; holds its value until the next good frame
- `rx_valid`  output  1  one-cycle strobe; `rx_byte` is new in the same cycle
- `rx_error`  output  1  one-cycle strobe signalling a framing error (stop bit sampled low)
- `rx_busy`  output  1  high while in START, DATA or STOP

## Operation
- `rx` passes through a two-flop synchronizer, whose output is `rx_s`. The synchronizer flops reset to 1.
- Bit counter width is `$clog2(CLKS_PER_BIT)`, 7 bits at the default parameters. The bit index is 3 bits, 0..7.
- States:
  - IDLE: when `rx_s`=0, clear the counter and go to START.
  - START: count to `HALF_BIT-1`, then sample `rx_s`. If it is 0, clear the counter and bit index and go to DATA. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: count to `CLKS_PER_BIT-1`, then shift `rx_s` into the MSB of the shift register. After the 8th sample go to STOP; otherwise increment the index.
  - STOP: count to `CLKS_PER_BIT-1`, then sample `rx_s`.
    - If it is 1: load `rx_byte` from the shift register, pulse `rx_valid`, go to IDLE.
    - If it is 0: pulse `rx_error`, leave `rx_byte` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. No start bit is accepted while in BREAK.
- The reset state is BREAK. After reset, the line must be seen high once before any start bit is accepted, so releasing reset mid-frame or while the line is held low never produces a spurious byte.
- Reset values: `rx_byte`=0x00, `rx_valid`=0, `rx_error`=0, `rx_busy`=0, shift register 0, counter 0, bit index 0.
- `rx_valid` and `rx_error` are mutually exclusive. Each is high for exactly one cycle per frame.
- `rst` overrides everything. Asserting it mid-frame aborts the frame with no strobe.

## Timing
- Let E0 be the clock edge at which IDLE sees `rx_s`=0. This is 2–3 clocks after the `rx` falling edge.
- Start-bit centre sample: edge E0+`HALF_BIT`.
- Data bit k (k=0..7) sample: edge E0+`HALF_BIT`+(k+1)·`CLKS_PER_BIT`.
- Stop-bit sample: edge E0+`HALF_BIT`+9·`CLKS_PER_BIT`, which is E0+988 at the defaults.
- `rx_valid`, `rx_error` and the new `rx_byte` are registered at the stop-sample edge. They are visible for the following cycle only.
- The block returns to IDLE at the stop-sample edge. A start bit arriving `HALF_BIT` clocks later, i.e. back-to-back frames, is caught without loss.
- `rx_busy` rises at edge E0. It falls at the stop-sample edge, or at the start-sample edge when a glitch is rejected.
- Tolerance: the sample point stays inside every bit for a baud mismatch of up to ±4%.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_HZ`, `BAUD` and `CLKS_PER_BIT`, common with the transmitter.
  - The state encoding: IDLE, START, DATA, STOP, BREAK.
- One sub-module, `sync_2ff`:
  - Single-bit two-flop synchronizer with a reset value parameter.
  - Instantiated here with reset value 1.
  - Reusable for other pin inputs.

## Test plan
- Reset, then hold `rx` high for 200 clocks and send 0x55 at 104 clk/bit → `rx_valid` for one cycle at E0+988 with `rx_byte`=0x55, and `rx_error` stays 0.
- Send 0xA5 and 0x3C back-to-back, with the second start bit immediately after the first stop bit → two `rx_valid` strobes 1040 clocks apart, carrying 0xA5 then 0x3C.
- Drive `rx` low for 30 clocks, then high → no strobe, `rx_busy` falls at E0+52, and a following 0x12 is received correctly.
- Send 0xFF with the stop bit low, then hold `rx` low for 2000 clocks → one `rx_error` strobe, `rx_byte` unchanged, no start accepted while low; after `rx` goes high, 0x12 is received correctly.
- Assert `rst` for 5 clocks while `rx` is low during data bit 3 of 0x81, and release it while still low → no strobe and outputs reset; after the line idles high, 0x7E is received correctly.
- Send 0xC3 at 100 clk/bit, then at 108 clk/bit → both received as 0xC3 with no `rx_error`.
